hdmi_sync_gen: RTL and testbench

Video timing generator and pixel-stream sink for the SoC's display output. It produces the `hsync`/`vsync`/data-enable waveform that the HDMI output pins and the simulation sync monitors consume. It pulls pixels from the frame-fetch stream with a valid/ready handshake during active video and flags underflow. It sits between the framebuffer DMA stream and the display pads.

---
 rtl/hdmi_sync_gen.sv | 176 +++++++++++++++++
 tb/tb_hdmi_sync_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_sync_gen.sv
// Video timing generator and pixel-stream sink for the display output.
// Define HDMI_SYNC_GEN_UNDERFLOW_CNT_EN to build the saturating underflow counter.

module hdmi_sync_gen #(
    parameter int CntWidth = 12,
    parameter int PixWidth = 24
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [CntWidth-1:0] h_active_i,
    input  logic [CntWidth-1:0] h_fp_i,
    input  logic [CntWidth-1:0] h_sync_i,
    input  logic [CntWidth-1:0] h_bp_i,
    input  logic [CntWidth-1:0] v_active_i,
    input  logic [CntWidth-1:0] v_fp_i,
    input  logic [CntWidth-1:0] v_sync_i,
    input  logic [CntWidth-1:0] v_bp_i,
    input  logic                hsync_pol_i,
    input  logic                vsync_pol_i,
    input  logic                pix_valid_i,
    input  logic [PixWidth-1:0] pix_data_i,
    output logic                pix_ready_o,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic                de_o,
    output logic [PixWidth-1:0] rgb_o,
    output logic [CntWidth-1:0] x_o,
    output logic [CntWidth-1:0] y_o,
    output logic                frame_start_o,
    output logic                underflow_o,
    input  logic                clr_i,
    output logic [15:0]         underflow_cnt_o
);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    typedef logic [CntWidth-1:0] cnt_t;

    function automatic cnt_t norm_len(input cnt_t len);
        return (len == '0) ? cnt_t'(1) : len;
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            PH_ACTIVE: return PH_FP;
            PH_FP:     return PH_SYNC;
            PH_SYNC:   return PH_BP;
            default:   return PH_ACTIVE;
        endcase
    endfunction

    // Shadow phase lengths, indexed by phase; zero lengths are stored as 1.
    logic [3:0][CntWidth-1:0] h_len_q;
    logic [3:0][CntWidth-1:0] v_len_q;

    logic   en_q;
    phase_e h_state;
    phase_e v_state;
    cnt_t   h_cnt;
    cnt_t   v_cnt;

    logic h_last;
    logic v_last;
    logic line_end;
    logic frame_end;
    logic load;

    assign h_last    = (h_cnt == h_len_q[h_state] - cnt_t'(1));
    assign v_last    = (v_cnt == v_len_q[v_state] - cnt_t'(1));
    assign line_end  = (h_state == PH_BP) && h_last;
    assign frame_end = line_end && (v_state == PH_BP) && v_last;
    assign load      = (en_i && !en_q) || (en_q && frame_end);

    // NOTE: the shadow registers are reset explicitly even though they are always
    // loaded before use; an unreset register array simulates as X and is not portable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_len_q <= '0;
            v_len_q <= '0;
        end else if (load) begin
            h_len_q <= {norm_len(h_bp_i), norm_len(h_sync_i),
                        norm_len(h_fp_i), norm_len(h_active_i)};
            v_len_q <= {norm_len(v_bp_i), norm_len(v_sync_i),
                        norm_len(v_fp_i), norm_len(v_active_i)};
        end
    end

    // Outputs decode the current position one edge after it is reached, so an
    // enable sampled at edge k produces the first active pixel at edge k+1.
    // NOTE: every sequential assignment is non-blocking so all flops see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q          <= 1'b0;
            h_state       <= PH_ACTIVE;
            v_state       <= PH_ACTIVE;
            h_cnt         <= '0;
            v_cnt         <= '0;
            hsync_o       <= 1'b0;
            vsync_o       <= 1'b0;
            de_o          <= 1'b0;
            frame_start_o <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
        end else begin
            en_q <= en_i;
            if (!en_q) begin
                h_state       <= PH_ACTIVE;
                v_state       <= PH_ACTIVE;
                h_cnt         <= '0;
                v_cnt         <= '0;
                hsync_o       <= ~hsync_pol_i;
                vsync_o       <= ~vsync_pol_i;
                de_o          <= 1'b0;
                frame_start_o <= 1'b0;
                x_o           <= '0;
                y_o           <= '0;
            end else begin
                de_o          <= (h_state == PH_ACTIVE) && (v_state == PH_ACTIVE);
                x_o           <= ((h_state == PH_ACTIVE) && (v_state == PH_ACTIVE)) ? h_cnt : '0;
                y_o           <= ((h_state == PH_ACTIVE) && (v_state == PH_ACTIVE)) ? v_cnt : '0;
                frame_start_o <= (h_state == PH_ACTIVE) && (h_cnt == '0) &&
                                 (v_state == PH_ACTIVE) && (v_cnt == '0);
                hsync_o       <= (h_state == PH_SYNC) ? hsync_pol_i : ~hsync_pol_i;
                // The vertical state only moves at a line boundary, so vsync does too.
                vsync_o       <= (v_state == PH_SYNC) ? vsync_pol_i : ~vsync_pol_i;

                if (h_last) begin
                    h_state <= next_phase(h_state);
                    h_cnt   <= '0;
                end else begin
                    h_cnt <= h_cnt + cnt_t'(1);
                end

                if (line_end) begin
                    if (v_last) begin
                        v_state <= next_phase(v_state);
                        v_cnt   <= '0;
                    end else begin
                        v_cnt <= v_cnt + cnt_t'(1);
                    end
                end
            end
        end
    end

    assign pix_ready_o = de_o;
    assign underflow_o = de_o && !pix_valid_i;
    assign rgb_o       = (de_o && pix_valid_i) ? pix_data_i : '0;

`ifdef HDMI_SYNC_GEN_UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            uf_cnt_q <= '0;
        end else if (clr_i) begin
            uf_cnt_q <= '0;
        end else if (underflow_o && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_q <= uf_cnt_q + 16'd1;
        end
    end

    assign underflow_cnt_o = uf_cnt_q;
`else
    logic unused_clr;
    assign unused_clr      = clr_i;
    assign underflow_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hdmi_sync_gen.sv
// Directed bench for hdmi_sync_gen: a geometric model of the expected waveform
// checked cycle by cycle, plus directed enable, reset and underflow-counter steps.

module tb_hdmi_sync_gen;

    localparam int CW = 12;
    localparam int PW = 24;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [CW-1:0] h_active, h_fp, h_sync, h_bp;
    logic [CW-1:0] v_active, v_fp, v_sync, v_bp;
    logic          hsync_pol, vsync_pol;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          pix_ready;
    logic          hsync, vsync, de;
    logic [PW-1:0] rgb;
    logic [CW-1:0] x, y;
    logic          frame_start;
    logic          underflow;
    logic          clr;
    logic [15:0]   underflow_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Geometry the model expects; changed only when the DUT should pick it up.
    int g_ha = 4, g_hf = 1, g_hs = 2, g_hb = 1;
    int g_va = 3, g_vf = 1, g_vs = 1, g_vb = 1;
    int g_origin = 0;

    hdmi_sync_gen #(.CntWidth(CW), .PixWidth(PW)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .en_i            (en),
        .h_active_i      (h_active),
        .h_fp_i          (h_fp),
        .h_sync_i        (h_sync),
        .h_bp_i          (h_bp),
        .v_active_i      (v_active),
        .v_fp_i          (v_fp),
        .v_sync_i        (v_sync),
        .v_bp_i          (v_bp),
        .hsync_pol_i     (hsync_pol),
        .vsync_pol_i     (vsync_pol),
        .pix_valid_i     (pix_valid),
        .pix_data_i      (pix_data),
        .pix_ready_o     (pix_ready),
        .hsync_o         (hsync),
        .vsync_o         (vsync),
        .de_o            (de),
        .rgb_o           (rgb),
        .x_o             (x),
        .y_o             (y),
        .frame_start_o   (frame_start),
        .underflow_o     (underflow),
        .clr_i           (clr),
        .underflow_cnt_o (underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks cycles c0..c0+n-1 against the frame geometry; pix_valid drops at drop_c.
    task automatic run_cycles(input int c0, input int n, input int drop_c);
        int   c, r, p, ln, line_len, frame_lines;
        logic e_de, e_hs, e_vs, e_fs;
        line_len    = g_ha + g_hf + g_hs + g_hb;
        frame_lines = g_va + g_vf + g_vs + g_vb;
        for (int i = 0; i < n; i++) begin
            c         = c0 + i;
            pix_valid = (c != drop_c);
            pix_data  = PW'(c + 'h10_0000);
            #1;
            r    = c - g_origin;
            p    = r % line_len;
            ln   = (r / line_len) % frame_lines;
            e_de = (p < g_ha) && (ln < g_va);
            e_hs = (p >= g_ha + g_hf) && (p < g_ha + g_hf + g_hs);
            e_vs = (ln >= g_va + g_vf) && (ln < g_va + g_vf + g_vs);
            e_fs = (p == 0) && (ln == 0);
            check($sformatf("de@%0d", c), 32'(de), 32'(e_de));
            check($sformatf("x@%0d", c), 32'(x), e_de ? 32'(p) : 32'd0);
            check($sformatf("y@%0d", c), 32'(y), e_de ? 32'(ln) : 32'd0);
            check($sformatf("hsync@%0d", c), 32'(hsync), 32'(e_hs ? hsync_pol : !hsync_pol));
            check($sformatf("vsync@%0d", c), 32'(vsync), 32'(e_vs ? vsync_pol : !vsync_pol));
            check($sformatf("frame_start@%0d", c), 32'(frame_start), 32'(e_fs));
            check($sformatf("pix_ready@%0d", c), 32'(pix_ready), 32'(e_de));
            check($sformatf("underflow@%0d", c), 32'(underflow), 32'(e_de && !pix_valid));
            check($sformatf("rgb@%0d", c), 32'(rgb), (e_de && pix_valid) ? 32'(pix_data) : 32'd0);
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b1;
    endtask

    initial begin
        int exp_cnt;
        rst_n     = 1'b0;
        en        = 1'b0;
        h_active  = 12'd4; h_fp = 12'd1; h_sync = 12'd2; h_bp = 12'd1;
        v_active  = 12'd3; v_fp = 12'd1; v_sync = 12'd1; v_bp = 12'd1;
        hsync_pol = 1'b1;
        vsync_pol = 1'b1;
        pix_valid = 1'b1;
        pix_data  = '0;
        clr       = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_de", 32'(de), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd0);
        check("rst_vsync", 32'(vsync), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_uf_cnt", 32'(underflow_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame: enable sampled at edge k, first pixel at edge k+1
        en = 1'b1;
        tick();
        check("en_edge_de", 32'(de), 32'd0);
        check("en_edge_hsync_idle", 32'(hsync), 32'd0);
        tick();
        run_cycles(0, 49, -1);

        // Underflow at x=2 of line 1 in the second frame
        run_cycles(49, 48, 58);
`ifdef HDMI_SYNC_GEN_UNDERFLOW_CNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        check("uf_cnt_after_drop", 32'(underflow_cnt), 32'(exp_cnt));

        // Inverted polarity for a full frame
        hsync_pol = 1'b0;
        vsync_pol = 1'b0;
        tick();
        run_cycles(98, 47, -1);

        // Mid-frame h_active change only lands at the next frame
        h_active = 12'd6;
        run_cycles(145, 47, -1);
        g_ha     = 6;
        g_origin = 192;
        run_cycles(192, 61, -1);

        // Enable dropped so that the last active output is x=2
        check("pre_dis_x", 32'(x), 32'd1);
        en = 1'b0;
        tick();
        check("dis_k_de", 32'(de), 32'd1);
        check("dis_k_x", 32'(x), 32'd2);
        tick();
        check("dis_de", 32'(de), 32'd0);
        check("dis_x", 32'(x), 32'd0);
        check("dis_y", 32'(y), 32'd0);
        check("dis_hsync_idle", 32'(hsync), 32'd1);
        check("dis_vsync_idle", 32'(vsync), 32'd1);
        check("dis_pix_ready", 32'(pix_ready), 32'd0);
        check("dis_rgb", 32'(rgb), 32'd0);
        repeat (3) tick();
        check("dis_hold_de", 32'(de), 32'd0);

        // Re-enable starts a fresh frame
        hsync_pol = 1'b1;
        vsync_pol = 1'b1;
        en = 1'b1;
        tick();
        check("reen_edge_de", 32'(de), 32'd0);
        tick();
        g_origin = 1000;
        run_cycles(1000, 8, -1);

        // Asynchronous reset in the middle of H_SYNC
        check("pre_rst_hsync", 32'(hsync), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_hsync", 32'(hsync), 32'd0);
        check("arst_vsync", 32'(vsync), 32'd0);
        check("arst_de", 32'(de), 32'd0);
        check("arst_frame_start", 32'(frame_start), 32'd0);
        check("arst_x", 32'(x), 32'd0);
        check("arst_y", 32'(y), 32'd0);
        check("arst_uf_cnt", 32'(underflow_cnt), 32'd0);
        en       = 1'b0;
        h_active = 12'd4;
        g_ha     = 4;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Underflow counting and clear-wins
        en        = 1'b1;
        pix_valid = 1'b0;
        tick();
        tick();
        check("uf_pulse", 32'(underflow), 32'd1);
        check("uf_rgb", 32'(rgb), 32'd0);
        check("uf_pix_ready", 32'(pix_ready), 32'd1);
        tick();
        tick();
`ifdef HDMI_SYNC_GEN_UNDERFLOW_CNT_EN
        exp_cnt = 2;
`else
        exp_cnt = 0;
`endif
        check("uf_cnt_two", 32'(underflow_cnt), 32'(exp_cnt));
        check("uf_during_clr", 32'(underflow), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("uf_cnt_clr_wins", 32'(underflow_cnt), 32'd0);
        tick();
`ifdef HDMI_SYNC_GEN_UNDERFLOW_CNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        check("uf_cnt_after_clr", 32'(underflow_cnt), 32'(exp_cnt));

`ifdef HDMI_SYNC_GEN_UNDERFLOW_CNT_EN
        // More than 0xFFFF underflows: 17 lines of 4095 starved active pixels
        en = 1'b0;
        repeat (2) tick();
        h_active = 12'd4095; h_fp = 12'd1; h_sync = 12'd1; h_bp = 12'd1;
        v_active = 12'd17;
        en = 1'b1;
        repeat (17 * 4098 + 4) @(posedge clk);
        #1;
        check("uf_cnt_saturated", 32'(underflow_cnt), 32'h0000_FFFF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("uf_cnt_sat_clr", 32'(underflow_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
